fm_audio_spi_if: RTL
====================

FM_AUDIO_SPI_IF -- requirements
Module: fm_audio_spi_if

Interface
Parameters:
REQ-001 The block SHALL have parameter A, default 8: audio sample width in bits, 2's complement.
REQ-002 The block SHALL have parameter N, default 18: phase increment width in bits.
REQ-003 The block SHALL have parameter K, default 4: deviation coefficient width in bits.
REQ-004 The block SHALL have parameter L, default 2: deviation factor width in bits.
REQ-005 The block SHALL have parameter DIV_W, default 16: sample-rate divider width in bits.
REQ-006 The block SHALL have parameter DEPTH, default 4: audio FIFO depth in entries, power of 2.
Ports (name, direction, width, meaning):
REQ-007 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-009 The block SHALL have port sclk, input, 1: SPI clock, asynchronous to clk.
REQ-010 The block SHALL have port cs_n, input, 1: SPI chip select, active-low, asynchronous.
REQ-011 The block SHALL have port mosi, input, 1: SPI data, MSB first, asynchronous.
REQ-012 The block SHALL have port audio, output, A (signed): current audio sample to the modulator.
REQ-013 The block SHALL have port acc_inc, output, N: carrier phase increment.
REQ-014 The block SHALL have port df_inc_coef, output, K: deviation coefficient.
REQ-015 The block SHALL have port df_inc_fact, output, L: deviation factor.
REQ-016 The block SHALL have port sample_stb, output, 1: one-cycle pulse when audio loads a new sample.
REQ-017 The block SHALL have port fifo_level, output, log2(DEPTH)+1: FIFO occupancy.
REQ-018 The block SHALL have port underrun, output, 1: sticky flag, a sample tick found the FIFO empty.
REQ-019 The block SHALL have port overflow, output, 1: sticky flag, an audio write found the FIFO full.

Function
REQ-020 sclk, cs_n and mosi SHALL each pass through a 2-FF synchronizer; all edge detection SHALL use the synchronized values only.
REQ-021 Bit capture: on each synchronized sclk rising edge while synchronized cs_n=0, mosi SHALL shift into a 24-bit shift register (MSB first) and a 5-bit bit counter SHALL increment, saturating at 31.
REQ-022 Synchronized cs_n falling edge SHALL clear the bit counter.
REQ-023 Frame commit: on a synchronized cs_n rising edge, the frame SHALL commit only if the bit count = 24 exactly; any other count SHALL discard the frame with no side effects.
REQ-024 Frame format SHALL be addr = frame[23:20], data = frame[19:0].
REQ-025 addr 0 SHALL push data[A-1:0] into the audio FIFO.
REQ-026 addr 1 SHALL load acc_inc <= data[N-1:0].
REQ-027 addr 2 SHALL load df_inc_coef <= data[K-1:0] and df_inc_fact <= data[K+L-1:K].
REQ-028 addr 3 SHALL load the divider from data[DIV_W-1:0] and clear the tick counter.
REQ-029 addr 4 SHALL clear underrun where data[0]=1 and overflow where data[1]=1.
REQ-030 addr 5-15 SHALL be ignored.
REQ-031 Register outputs SHALL change on the clk edge following the cycle in which the synchronized cs_n rise is detected (1-cycle commit latency).
REQ-032 Sample tick: the tick counter SHALL count 0..div and the tick SHALL assert in the cycle counter==div, after which the counter returns to 0; div=0 SHALL tick every cycle.
REQ-033 On a tick with the FIFO non-empty: the head SHALL pop, audio <= head on the next edge, and sample_stb=1 for exactly that cycle.
REQ-034 On a tick with the FIFO empty: audio SHALL hold its value, sample_stb SHALL stay 0, and underrun SHALL set.
REQ-035 A push when full SHALL drop the sample and set overflow.
REQ-036 A push and a tick in the same cycle with the FIFO full SHALL pop first then accept the push, with no overflow.
REQ-037 A push and a tick in the same cycle with the FIFO empty SHALL raise underrun and store the pushed sample.
REQ-038 fifo_level SHALL reflect the registered occupancy, 0..DEPTH; FIFO pointers SHALL wrap modulo DEPTH.
REQ-039 A flag clear (addr 4) coinciding with a new set event SHALL leave the flag set.

Reset
REQ-040 While rst_n=0 at a clk edge, the block SHALL set audio=0, acc_inc=0, df_inc_coef=0, df_inc_fact=0, sample_stb=0, fifo_level=0, underrun=0, overflow=0.
REQ-041 While rst_n=0 at a clk edge, the block SHALL set divider=1249 and tick counter=0.
REQ-042 While rst_n=0 at a clk edge, the block SHALL set shift register=0 and bit counter=0, set the cs_n synchronizer stages to 1, and set the sclk synchronizer stages to 0.
REQ-043 Reset asserted mid-frame SHALL discard the partial frame; a frame whose cs_n falling edge occurred before reset release SHALL NOT commit.

Verification
REQ-044 A bench SHALL cover: write addr1 data 0x12345 -> acc_inc=0x12345 one cycle after synchronized cs_n rise; other outputs unchanged.
REQ-045 A bench SHALL cover: div=3, push samples 0x10, 0x80, 0x7F -> audio steps through 16, -128, 127 on ticks 4 cycles apart with a sample_stb pulse each; the 4th tick sets underrun and audio stays 127.
REQ-046 A bench SHALL cover: 5 pushes with no ticks (div=0xFFFF) -> fifo_level=4, overflow=1, 5th sample lost; addr4 data 0x2 -> overflow=0.
REQ-047 A bench SHALL cover: 23-bit and 25-bit frames to addr1 -> acc_inc unchanged, no flags.
REQ-048 A bench SHALL cover: FIFO full with div=0 and a push in the same cycle -> no overflow, fifo_level stays 4.
REQ-049 A bench SHALL cover: rst_n low after 12 bits of a frame, then cs_n rise -> no commit, all outputs at reset values.

Source files
------------

// File: rtl/fm_audio_spi_if_if.sv
// SPI control bus feeding the FM audio front end: serial clock, chip
// select and data, all driven by an external master in its own clock domain.
interface fm_audio_spi_if_if;
    logic sclk;
    logic cs_n;
    logic mosi;

    modport master (output sclk, output cs_n, output mosi);
    modport slave  (input  sclk, input  cs_n, input  mosi);
endinterface

// File: rtl/fm_audio_spi_if.sv
// SPI register/audio front end for the FM modulator.
// Receives 24-bit frames {addr[3:0], data[19:0]} over an asynchronous SPI
// link, programs carrier/deviation registers and feeds audio samples through
// a small FIFO that is drained at a programmable sample rate.
module fm_audio_spi_if #(
    parameter int A     = 8,
    parameter int N     = 18,
    parameter int K     = 4,
    parameter int L     = 2,
    parameter int DIV_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fm_audio_spi_if_if.slave         spi,
    output logic signed [A-1:0]      audio,
    output logic [N-1:0]             acc_inc,
    output logic [K-1:0]             df_inc_coef,
    output logic [L-1:0]             df_inc_fact,
    output logic                     sample_stb,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic                     overflow
);

    localparam int                PW         = $clog2(DEPTH);
    localparam int                LW         = PW + 1;
    localparam logic [LW-1:0]     FULL_LVL   = LW'(DEPTH);
    localparam logic [DIV_W-1:0]  DIV_RST    = DIV_W'(1249);
    localparam logic [4:0]        FRAME_BITS = 5'd24;

    // Bit counter saturates so that long frames can never wrap back to 24.
    function automatic logic [4:0] sat_inc5(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    // Sticky flag update: a set event always wins over a simultaneous clear.
    function automatic logic flag_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       cs_prev;
    logic [1:0] sync_vld;

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;

    // Two-flop synchronizers plus one history flop each for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            sync_vld  <= 2'b00;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.sclk};
            cs_sync   <= {cs_sync[0],   spi.cs_n};
            mosi_sync <= {mosi_sync[0], spi.mosi};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
            sync_vld  <= {sync_vld[0], 1'b1};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign cs_fall   = ~cs_sync[1] & cs_prev;
    assign cs_rise   = cs_sync[1] & ~cs_prev;

    // ------------------------------------------------------------------
    // Frame capture
    // ------------------------------------------------------------------
    // cs_idle_ok only sets once a real (post-reset) idle-high chip select
    // has been observed; the reset value of the synchronizer is not trusted.
    // A frame is only "open" if its falling edge followed such an idle level,
    // so a frame already in progress across reset release can never commit.
    logic [23:0] shreg;
    logic [4:0]  bitcnt;
    logic        cs_idle_ok;
    logic        frame_open;

    // Shift register, bit counter and frame-validity tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg      <= '0;
            bitcnt     <= '0;
            cs_idle_ok <= 1'b0;
            frame_open <= 1'b0;
        end else begin
            if (sync_vld[1] && cs_sync[1]) begin
                cs_idle_ok <= 1'b1;
            end
            if (sclk_rise && !cs_sync[1]) begin
                shreg <= {shreg[22:0], mosi_sync[1]};
            end
            if (cs_fall) begin
                bitcnt     <= sclk_rise ? 5'd1 : 5'd0;
                frame_open <= cs_idle_ok;
            end else if (sclk_rise && !cs_sync[1]) begin
                bitcnt <= sat_inc5(bitcnt);
            end
            if (cs_rise) begin
                frame_open <= 1'b0;
            end
        end
    end

    logic        commit;
    logic [3:0]  faddr;
    logic [19:0] fdata;
    logic        wr_audio;
    logic        wr_acc;
    logic        wr_dev;
    logic        wr_div;
    logic        wr_flags;
    logic        unused_frame_bits;

    assign commit   = cs_rise && frame_open && (bitcnt == FRAME_BITS);
    assign faddr    = shreg[23:20];
    assign fdata    = shreg[19:0];
    assign wr_audio = commit && (faddr == 4'd0);
    assign wr_acc   = commit && (faddr == 4'd1);
    assign wr_dev   = commit && (faddr == 4'd2);
    assign wr_div   = commit && (faddr == 4'd3);
    assign wr_flags = commit && (faddr == 4'd4);

    // Upper data bits are meaningful only for some parameterizations.
    assign unused_frame_bits = ^fdata;

    // ------------------------------------------------------------------
    // Modulator control registers
    // ------------------------------------------------------------------
    // Carrier increment and deviation settings, loaded straight from frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_inc     <= '0;
            df_inc_coef <= '0;
            df_inc_fact <= '0;
        end else begin
            if (wr_acc) begin
                acc_inc <= fdata[N-1:0];
            end
            if (wr_dev) begin
                df_inc_coef <= fdata[K-1:0];
                df_inc_fact <= fdata[K+L-1:K];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample-rate tick
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] tcnt;
    logic             tick;

    assign tick = (tcnt == div_q);

    // Counts 0..div, ticking on div; reloading the divider restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= DIV_RST;
            tcnt  <= '0;
        end else if (wr_div) begin
            div_q <= fdata[DIV_W-1:0];
            tcnt  <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Audio FIFO
    // ------------------------------------------------------------------
    logic signed [A-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push_ok;
    logic                push_drop;

    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == FULL_LVL);
    assign pop        = tick && !fifo_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok    = wr_audio && (!fifo_full || pop);
    assign push_drop  = wr_audio && fifo_full && !pop;

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= $signed(fdata[A-1:0]);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Present the popped head to the modulator with a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            audio      <= '0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= pop;
            if (pop) begin
                audio <= mem[rd_ptr];
            end
        end
    end

    // Sticky error flags, cleared by an addr-4 frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            underrun <= flag_next(underrun, tick && fifo_empty, wr_flags && fdata[0]);
            overflow <= flag_next(overflow, push_drop,          wr_flags && fdata[1]);
        end
    end

endmodule
